// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, zero-register tag and the CDB packet layout used by the
// result slots and the broadcast register.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU    = 4;
  localparam int CDB_DATA_W    = 64;
  localparam int CDB_PRF_IDX_W = 6;
  localparam int CDB_ROB_IDX_W = 5;

  // Architectural zero register: still broadcast for ROB completion, never written.
  localparam logic [CDB_PRF_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [CDB_PRF_IDX_W-1:0] tag;
    logic [CDB_DATA_W-1:0]    data;
    logic [CDB_ROB_IDX_W-1:0] rob;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping
// modulo NUM_FU (non-power-of-2 counts are fine).
module cdb_rr_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [PTR_W-1:0]  winner,
  output logic              any_grant
);

  int idx;

  // Scan NUM_FU positions starting at ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_FU; off++) begin
      idx = (int'(ptr) + off) % NUM_FU;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: one-entry result slot per FU, round-robin pick of a
// full slot each cycle, registered broadcast to PRF / RS wakeup / ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = CDB_NUM_FU,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int PRF_IDX_W = CDB_PRF_IDX_W,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [NUM_FU-1:0]             fu_valid_i,
  input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_tag_i,
  input  logic [NUM_FU*DATA_W-1:0]      fu_data_i,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_i,
  output logic [NUM_FU-1:0]             fu_ready_o,
  output logic                          cdb_valid_o,
  output logic [PRF_IDX_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]             cdb_data_o,
  output logic [ROB_IDX_W-1:0]          cdb_rob_o,
  output logic                          cdb_wr_en_o
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  cdb_pkt_t [NUM_FU-1:0] slot_pkt;
  logic     [NUM_FU-1:0] slot_full;
  logic     [NUM_FU-1:0] req;
  logic     [NUM_FU-1:0] grant;
  logic     [PTR_W-1:0]  rr_ptr;
  logic     [PTR_W-1:0]  winner;
  logic     [PTR_W-1:0]  rr_ptr_nxt;
  logic                  any_grant;
  cdb_pkt_t              cdb_pkt_q;
  logic                  cdb_valid_q;

  // Flush suppresses every grant, so nothing leaves a slot that is being squashed.
  assign req = slot_full & {NUM_FU{~flush_i}};

  cdb_rr_arbiter #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // A slot accepts when empty or when it drains this cycle; independent of fu_valid_i.
  assign fu_ready_o = {NUM_FU{~flush_i}} & (~slot_full | grant);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    cdb_pkt_t pkt_d;
    cdb_pkt_t pkt_q;
    logic     full_q;

    assign pkt_d.tag  = fu_tag_i [i*PRF_IDX_W +: PRF_IDX_W];
    assign pkt_d.data = fu_data_i[i*DATA_W    +: DATA_W];
    assign pkt_d.rob  = fu_rob_i [i*ROB_IDX_W +: ROB_IDX_W];

    // Slot: flush empties, accept loads (also reloads on grant), grant alone empties.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_q <= 1'b0;
        pkt_q  <= '0;
      end else if (flush_i) begin
        full_q <= 1'b0;
      end else if (fu_valid_i[i] && fu_ready_o[i]) begin
        full_q <= 1'b1;
        pkt_q  <= pkt_d;
      end else if (grant[i]) begin
        full_q <= 1'b0;
      end
    end

    assign slot_full[i] = full_q;
    assign slot_pkt[i]  = pkt_q;
  end

  // Explicit wrap keeps the pointer legal for non-power-of-2 NUM_FU.
  assign rr_ptr_nxt = (winner == PTR_W'(NUM_FU-1)) ? '0 : winner + 1'b1;

  // Broadcast register and round-robin pointer; data may go stale when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      rr_ptr      <= '0;
    end else if (any_grant) begin
      cdb_valid_q <= 1'b1;
      cdb_pkt_q   <= slot_pkt[winner];
      rr_ptr      <= rr_ptr_nxt;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_pkt_q.tag;
  assign cdb_data_o  = cdb_pkt_q.data;
  assign cdb_rob_o   = cdb_pkt_q.rob;
  assign cdb_wr_en_o = cdb_valid_q && (cdb_pkt_q.tag != ZERO_REG);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized + directed bench for cdb_arbiter against a cycle-level
// behavioural model of slots, round-robin order and broadcast.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TW = 6;
  localparam int RW = 5;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic [N-1:0]    fu_valid_i;
  logic [N*TW-1:0] fu_tag_i;
  logic [N*DW-1:0] fu_data_i;
  logic [N*RW-1:0] fu_rob_i;
  logic [N-1:0]    fu_ready_o;
  logic            cdb_valid_o;
  logic [TW-1:0]   cdb_tag_o;
  logic [DW-1:0]   cdb_data_o;
  logic [RW-1:0]   cdb_rob_o;
  logic            cdb_wr_en_o;

  cdb_arbiter u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .fu_valid_i  (fu_valid_i),
    .fu_tag_i    (fu_tag_i),
    .fu_data_i   (fu_data_i),
    .fu_rob_i    (fu_rob_i),
    .fu_ready_o  (fu_ready_o),
    .cdb_valid_o (cdb_valid_o),
    .cdb_tag_o   (cdb_tag_o),
    .cdb_data_o  (cdb_data_o),
    .cdb_rob_o   (cdb_rob_o),
    .cdb_wr_en_o (cdb_wr_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Stimulus values presented by each FU on the next step.
  logic [TW-1:0] s_tag  [N];
  logic [DW-1:0] s_data [N];
  logic [RW-1:0] s_rob  [N];

  // Reference model: slot contents, round-robin pointer, broadcast register.
  bit            m_full [N];
  logic [TW-1:0] m_tag  [N];
  logic [DW-1:0] m_data [N];
  logic [RW-1:0] m_rob  [N];
  int            m_ptr;
  bit            m_ov;
  logic [TW-1:0] m_otag;
  logic [DW-1:0] m_odata;
  logic [RW-1:0] m_orob;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 0;
    m_ptr = 0;
    m_ov  = 0;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                        input logic [RW-1:0] r);
    s_tag[i] = t; s_data[i] = d; s_rob[i] = r;
  endtask

  // One clock: check broadcast, drive inputs, check ready, advance model, take the edge.
  task automatic step(input logic [N-1:0] v, input logic fl);
    int w;
    logic [N-1:0] er;
    @(negedge clk);
    chk("cdb_valid", cdb_valid_o, m_ov);
    chk("cdb_wr_en", cdb_wr_en_o, m_ov && (m_otag != 0));
    if (m_ov) begin
      chk("cdb_tag",  cdb_tag_o,  m_otag);
      chk("cdb_data", cdb_data_o, m_odata);
      chk("cdb_rob",  cdb_rob_o,  m_orob);
    end
    fu_valid_i = v;
    flush_i    = fl;
    for (int i = 0; i < N; i++) begin
      fu_tag_i [i*TW +: TW] = s_tag[i];
      fu_data_i[i*DW +: DW] = s_data[i];
      fu_rob_i [i*RW +: RW] = s_rob[i];
    end
    #1;
    w = -1;
    if (!fl)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && m_full[j]) w = j;
      end
    for (int i = 0; i < N; i++) er[i] = !fl && (!m_full[i] || i == w);
    chk("fu_ready", fu_ready_o, er);
    if (fl) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_ov = 0;
    end else begin
      if (w >= 0) begin
        m_ov = 1; m_otag = m_tag[w]; m_odata = m_data[w]; m_orob = m_rob[w];
        m_full[w] = 0;
        m_ptr = (w + 1) % N;
      end else begin
        m_ov = 0;
      end
      for (int i = 0; i < N; i++)
        if (v[i] && er[i]) begin
          m_full[i] = 1; m_tag[i] = s_tag[i]; m_data[i] = s_data[i]; m_rob[i] = s_rob[i];
        end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge, check outputs immediately, release at negedge.
  task automatic async_reset();
    fu_valid_i = '0;
    flush_i    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", cdb_valid_o, 0);
    chk("rst_wr_en", cdb_wr_en_o, 0);
    chk("rst_tag",   cdb_tag_o,   0);
    chk("rst_data",  cdb_data_o,  0);
    chk("rst_rob",   cdb_rob_o,   0);
    chk("rst_ready", fu_ready_o,  4'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; flush_i = 1'b0; fu_valid_i = '0;
    fu_tag_i = '0; fu_data_i = '0; fu_rob_i = '0;
    for (int i = 0; i < N; i++) set_fu(i, '0, '0, '0);
    model_reset();
    #3;
    async_reset();

    // Single FU0 result: broadcast two edges after the handshake.
    set_fu(0, 6'd5, 64'hDEAD, 5'd3);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    chk("t1_valid", cdb_valid_o, 1);
    chk("t1_tag",   cdb_tag_o,   5);
    chk("t1_data",  cdb_data_o,  64'hDEAD);
    chk("t1_rob",   cdb_rob_o,   3);
    chk("t1_wr_en", cdb_wr_en_o, 1);
    step(4'b0000, 1'b0);
    chk("t1_once", cdb_valid_o, 0);

    // All FUs streaming from rr_ptr=0: strict 0,1,2,3 rotation.
    async_reset();
    for (int i = 0; i < N; i++) set_fu(i, TW'(8 + i), DW'(64'h1000 + i), RW'(i));
    for (int k = 0; k < 9; k++) begin
      step(4'b1111, 1'b0);
      if (k >= 1) chk("rr_order", cdb_tag_o, 8 + ((k - 1) % N));
    end
    for (int k = 0; k < 5; k++) step(4'b0000, 1'b0);

    // Zero-register destination: completes but does not write the PRF.
    set_fu(2, 6'd0, 64'h55, 5'd7);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("zr_valid", cdb_valid_o, 1);
    chk("zr_rob",   cdb_rob_o,   7);
    chk("zr_wr_en", cdb_wr_en_o, 0);
    step(4'b0000, 1'b0);

    // FU1 alone: grant and reload on the same edge, back-to-back broadcasts.
    for (int j = 0; j < 6; j++) begin
      set_fu(1, 6'd20, DW'(100 + j), 5'd9);
      step(4'b0010, 1'b0);
      if (j >= 1) begin
        chk("b2b_valid", cdb_valid_o, 1);
        chk("b2b_data",  cdb_data_o,  100 + j - 1);
      end
    end
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);

    // Flush with slots 0 and 3 full: neither result ever appears.
    set_fu(0, 6'd33, 64'hA0, 5'd1);
    set_fu(3, 6'd34, 64'hA3, 5'd2);
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b1);
    chk("fl_valid", cdb_valid_o, 0);
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);

    // Reset mid-operation with three slots full; no stale broadcast afterwards.
    set_fu(0, 6'd40, 64'hB0, 5'd4);
    set_fu(1, 6'd41, 64'hB1, 5'd5);
    set_fu(2, 6'd42, 64'hB2, 5'd6);
    step(4'b0111, 1'b0);
    async_reset();
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b0);

    // Random traffic with occasional flush and zero-register tags.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        set_fu(i, ($urandom_range(0, 3) == 0) ? 6'd0 : TW'($urandom),
               {$urandom, $urandom}, RW'($urandom));
      step(N'($urandom), ($urandom_range(0, 15) == 0));
    end
    step(4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
